// File: rtl/jtag_tap_ir_ctrl.sv
// JTAG TAP controller: 16-state one-hot TAP FSM, instruction register, bypass register and DR-select decode.
// Optional feature macro: JTAG_IDCODE_EN adds a 32-bit IDCODE register, which also becomes the reset instruction.
module jtag_tap_ir_ctrl #(
   parameter int                  IR_WIDTH     = 4,
   parameter int                  NUM_USER_DR  = 2,
   parameter logic [IR_WIDTH-1:0] USER_OP_BASE = 4'h2,
   parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 4'h1,
   parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001
) (
   input  logic                   tck,
   input  logic                   trst_n,
   input  logic                   tms,
   input  logic                   tdi,
   output logic                   tdo,
   output logic                   tdo_en,
   input  logic [NUM_USER_DR-1:0] user_tdo,
   output logic [NUM_USER_DR-1:0] dr_sel,
   output logic                   capture_dr,
   output logic                   shift_dr,
   output logic                   update_dr,
   output logic                   tlr,
   output logic [IR_WIDTH-1:0]    ir_out
);

   localparam int MAX_USER_OP = int'(USER_OP_BASE) + NUM_USER_DR - 1;
   localparam int ALL_ONES_OP = (1 << IR_WIDTH) - 1;

   if (IR_WIDTH < 2) begin : g_chk_ir_width
      $error("jtag_tap_ir_ctrl: IR_WIDTH must be at least 2");
   end
   if (NUM_USER_DR < 1 || NUM_USER_DR > 8) begin : g_chk_num_user
      $error("jtag_tap_ir_ctrl: NUM_USER_DR must be in 1..8");
   end
   if (MAX_USER_OP >= ALL_ONES_OP) begin : g_chk_user_range
      $error("jtag_tap_ir_ctrl: user opcodes collide with the all-ones BYPASS opcode");
   end
   if (int'(IDCODE_OP) >= int'(USER_OP_BASE) && int'(IDCODE_OP) <= MAX_USER_OP) begin : g_chk_idcode_op
      $error("jtag_tap_ir_ctrl: IDCODE_OP collides with a user chain opcode");
   end
   if (IDCODE_VALUE[0] != 1'b1) begin : g_chk_idcode_lsb
      $error("jtag_tap_ir_ctrl: IDCODE_VALUE bit 0 must be 1");
   end

`ifdef JTAG_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] RESET_OP = IDCODE_OP;
`else
   localparam logic [IR_WIDTH-1:0] RESET_OP = '1;
`endif

   // One-hot encoding: every state decode is a single flop output, so no decode glitches.
   typedef enum logic [15:0] {
      TLR    = 16'h0001,
      RTI    = 16'h0002,
      SEL_DR = 16'h0004,
      CAP_DR = 16'h0008,
      SH_DR  = 16'h0010,
      EX1_DR = 16'h0020,
      PAU_DR = 16'h0040,
      EX2_DR = 16'h0080,
      UPD_DR = 16'h0100,
      SEL_IR = 16'h0200,
      CAP_IR = 16'h0400,
      SH_IR  = 16'h0800,
      EX1_IR = 16'h1000,
      PAU_IR = 16'h2000,
      EX2_IR = 16'h4000,
      UPD_IR = 16'h8000
   } tap_state_t;

   localparam int I_TLR    = 0;
   localparam int I_CAP_DR = 3;
   localparam int I_SH_DR  = 4;
   localparam int I_UPD_DR = 8;
   localparam int I_SEL_IR = 9;
   localparam int I_CAP_IR = 10;
   localparam int I_SH_IR  = 11;
   localparam int I_UPD_IR = 15;

   tap_state_t          state;
   logic [IR_WIDTH-1:0] ir_shift;
   logic                bypass_reg;
   logic                dr_tdo;

`ifdef JTAG_IDCODE_EN
   logic                sel_idcode;
   logic [31:0]         idcode_reg;
`endif

   always_ff @(posedge tck or negedge trst_n) begin : tap_fsm
      if (!trst_n) begin
         state <= TLR;
      end else begin
         case (state)
            TLR:     state <= tms ? TLR    : RTI;
            RTI:     state <= tms ? SEL_DR : RTI;
            SEL_DR:  state <= tms ? SEL_IR : CAP_DR;
            CAP_DR:  state <= tms ? EX1_DR : SH_DR;
            SH_DR:   state <= tms ? EX1_DR : SH_DR;
            EX1_DR:  state <= tms ? UPD_DR : PAU_DR;
            PAU_DR:  state <= tms ? EX2_DR : PAU_DR;
            EX2_DR:  state <= tms ? UPD_DR : SH_DR;
            UPD_DR:  state <= tms ? SEL_DR : RTI;
            SEL_IR:  state <= tms ? TLR    : CAP_IR;
            CAP_IR:  state <= tms ? EX1_IR : SH_IR;
            SH_IR:   state <= tms ? EX1_IR : SH_IR;
            EX1_IR:  state <= tms ? UPD_IR : PAU_IR;
            PAU_IR:  state <= tms ? EX2_IR : PAU_IR;
            EX2_IR:  state <= tms ? UPD_IR : SH_IR;
            UPD_IR:  state <= tms ? SEL_DR : RTI;
            default: state <= TLR;
         endcase
      end
   end

   assign tlr        = state[I_TLR];
   assign capture_dr = state[I_CAP_DR];
   assign shift_dr   = state[I_SH_DR];
   assign update_dr  = state[I_UPD_DR];

   // ir_out snaps to the reset opcode on the same edge that enters TLR, and stays there while in TLR.
   always_ff @(posedge tck or negedge trst_n) begin : ir_path
      if (!trst_n) begin
         ir_shift <= '0;
         ir_out   <= RESET_OP;
      end else begin
         if (state[I_CAP_IR]) begin
            ir_shift <= IR_WIDTH'(2'b01);
         end else if (state[I_SH_IR]) begin
            ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
         end
         if (state[I_TLR] || (state[I_SEL_IR] && tms)) begin
            ir_out <= RESET_OP;
         end else if (state[I_UPD_IR]) begin
            ir_out <= ir_shift;
         end
      end
   end

   always_comb begin : ir_decode
      dr_sel = '0;
      for (int k = 0; k < NUM_USER_DR; k++) begin
         if (ir_out == USER_OP_BASE + IR_WIDTH'(k)) begin
            dr_sel[k] = 1'b1;
         end
      end
`ifdef JTAG_IDCODE_EN
      sel_idcode = (ir_out == IDCODE_OP);
`endif
   end

   always_ff @(posedge tck or negedge trst_n) begin : bypass_path
      if (!trst_n) begin
         bypass_reg <= 1'b0;
      end else if (state[I_CAP_DR]) begin
         bypass_reg <= 1'b0;
      end else if (state[I_SH_DR]) begin
         bypass_reg <= tdi;
      end
   end

`ifdef JTAG_IDCODE_EN
   always_ff @(posedge tck or negedge trst_n) begin : idcode_path
      if (!trst_n) begin
         idcode_reg <= IDCODE_VALUE;
      end else if (state[I_CAP_DR] && sel_idcode) begin
         idcode_reg <= IDCODE_VALUE;
      end else if (state[I_SH_DR] && sel_idcode) begin
         idcode_reg <= {tdi, idcode_reg[31:1]};
      end
   end
`endif

   // Bypass is the fallback source whenever no user chain or IDCODE is selected.
   always_comb begin : dr_mux
      dr_tdo = bypass_reg;
      for (int k = 0; k < NUM_USER_DR; k++) begin
         if (dr_sel[k]) begin
            dr_tdo = user_tdo[k];
         end
      end
`ifdef JTAG_IDCODE_EN
      if (sel_idcode) begin
         dr_tdo = idcode_reg[0];
      end
`endif
   end

   always_ff @(negedge tck or negedge trst_n) begin : tdo_launch
      if (!trst_n) begin
         tdo    <= 1'b0;
         tdo_en <= 1'b0;
      end else if (state[I_SH_IR]) begin
         tdo    <= ir_shift[0];
         tdo_en <= 1'b1;
      end else if (state[I_SH_DR]) begin
         tdo    <= dr_tdo;
         tdo_en <= 1'b1;
      end else begin
         tdo_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtag_tap_ir_ctrl.sv
// Directed self-checking bench for jtag_tap_ir_ctrl; expectations follow JTAG_IDCODE_EN when it is defined.
module tb_jtag_tap_ir_ctrl;

`ifdef JTAG_IDCODE_EN
   localparam logic [3:0] RESET_OP = 4'h1;
`else
   localparam logic [3:0] RESET_OP = 4'hF;
`endif

   logic       tck = 1'b0;
   logic       trst_n;
   logic       tms;
   logic       tdi;
   logic       tdo;
   logic       tdo_en;
   logic [1:0] user_tdo;
   logic [1:0] dr_sel;
   logic       capture_dr;
   logic       shift_dr;
   logic       update_dr;
   logic       tlr;
   logic [3:0] ir_out;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [3:0]  ir_capture = 4'b0001;
   logic [3:0]  exp_ir;
   logic [3:0]  byp_pat = 4'b1101;
   logic [3:0]  got4;
   logic [31:0] scan_pat = 32'hA5C3_0F96;
   logic [31:0] got32;
   logic [31:0] exp_scan;

   jtag_tap_ir_ctrl #(
      .IR_WIDTH    (4),
      .NUM_USER_DR (2),
      .USER_OP_BASE(4'h2),
      .IDCODE_OP   (4'h1),
      .IDCODE_VALUE(32'h1000_0001)
   ) dut (
      .tck       (tck),
      .trst_n    (trst_n),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo),
      .tdo_en    (tdo_en),
      .user_tdo  (user_tdo),
      .dr_sel    (dr_sel),
      .capture_dr(capture_dr),
      .shift_dr  (shift_dr),
      .update_dr (update_dr),
      .tlr       (tlr),
      .ir_out    (ir_out)
   );

   always #10 tck = ~tck;

   task automatic applyStimulus(input logic tms_v, input logic tdi_v);
      tms = tms_v;
      tdi = tdi_v;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Starts in TLR or RTI, ends in RTI with the new instruction applied.
   task automatic scan_ir(input logic [3:0] value);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("ir_tdo", {31'd0, tdo}, {31'd0, ir_capture[i]});
         checkOutput("ir_tdo_en", {31'd0, tdo_en}, 32'd1);
         if (i == 2) checkOutput("ir_stable_in_shift", {28'd0, ir_out}, {28'd0, exp_ir});
         applyStimulus(logic'(i == 3), value[i]);
      end
      checkOutput("ir_exit_tdo_en", {31'd0, tdo_en}, 32'd0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("ir_hold_in_update", {28'd0, ir_out}, {28'd0, exp_ir});
      applyStimulus(1'b0, 1'b0);
      exp_ir = value;
      checkOutput("ir_updated", {28'd0, ir_out}, {28'd0, value});
   endtask

   // From RTI into Shift-DR, checking the capture and shift decodes on the way.
   task automatic enter_shift_dr();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("capture_dr", {31'd0, capture_dr}, 32'd1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("shift_dr", {31'd0, shift_dr}, 32'd1);
      checkOutput("dr_tdo_en", {31'd0, tdo_en}, 32'd1);
   endtask

   initial begin
      trst_n   = 1'b0;
      tms      = 1'b1;
      tdi      = 1'b0;
      user_tdo = 2'b00;
      exp_ir   = RESET_OP;
      repeat (2) @(negedge tck);
      #1;
      checkOutput("rst_tlr", {31'd0, tlr}, 32'd1);
      checkOutput("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
      checkOutput("rst_tdo", {31'd0, tdo}, 32'd0);
      checkOutput("rst_ir_out", {28'd0, ir_out}, {28'd0, RESET_OP});
      checkOutput("rst_dr_sel", {30'd0, dr_sel}, 32'd0);
      trst_n = 1'b1;
      applyStimulus(1'b1, 1'b0);
      checkOutput("tlr_hold", {31'd0, tlr}, 32'd1);

      $display("[TB] IR scan 0x3 and user chain 1");
      scan_ir(4'h3);
      checkOutput("dr_sel_op3", {30'd0, dr_sel}, 32'h2);
      user_tdo = 2'b10;
      enter_shift_dr();
      checkOutput("user1_tdo_hi", {31'd0, tdo}, 32'd1);
      user_tdo = 2'b01;
      applyStimulus(1'b0, 1'b0);
      checkOutput("user1_tdo_lo", {31'd0, tdo}, 32'd0);

      $display("[TB] five tms=1 from Shift-DR");
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0);
         if (i == 2) checkOutput("update_dr", {31'd0, update_dr}, 32'd1);
         if (i < 5) begin
            checkOutput("tlr_not_yet", {31'd0, tlr}, 32'd0);
            checkOutput("ir_kept", {28'd0, ir_out}, 32'h3);
         end else begin
            checkOutput("tlr_fifth", {31'd0, tlr}, 32'd1);
            checkOutput("ir_back_to_reset", {28'd0, ir_out}, {28'd0, RESET_OP});
         end
      end
      exp_ir = RESET_OP;
      checkOutput("dr_sel_reset_op", {30'd0, dr_sel}, 32'd0);

      $display("[TB] decode of other opcodes");
      scan_ir(4'h2);
      checkOutput("dr_sel_op2", {30'd0, dr_sel}, 32'h1);
      scan_ir(4'h5);
      checkOutput("dr_sel_op5", {30'd0, dr_sel}, 32'd0);
      scan_ir(4'hF);
      checkOutput("dr_sel_opF", {30'd0, dr_sel}, 32'd0);

      $display("[TB] bypass scan");
      enter_shift_dr();
      got4[0] = tdo;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(logic'(i == 3), byp_pat[i]);
         if (i < 3) got4[i+1] = tdo;
      end
      checkOutput("bypass_tdo_seq", {28'd0, got4}, 32'hA);
      checkOutput("bypass_exit_tdo_en", {31'd0, tdo_en}, 32'd0);
      checkOutput("bypass_tdo_held", {31'd0, tdo}, 32'd1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] DR scan after reset");
      trst_n = 1'b0;
      applyStimulus(1'b1, 1'b0);
      trst_n = 1'b1;
      applyStimulus(1'b0, 1'b0);
      exp_ir = RESET_OP;
      checkOutput("ir_after_trst", {28'd0, ir_out}, {28'd0, RESET_OP});
      enter_shift_dr();
      got32[0] = tdo;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(logic'(i == 31), scan_pat[i]);
         if (i < 31) got32[i+1] = tdo;
      end
`ifdef JTAG_IDCODE_EN
      exp_scan = 32'h1000_0001;
`else
      exp_scan = {scan_pat[30:0], 1'b0};
`endif
      checkOutput("reset_dr_scan", got32, exp_scan);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] trst_n during IR shift");
      scan_ir(4'h3);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("mid_shift_ir_stable", {28'd0, ir_out}, 32'h3);
      checkOutput("mid_shift_tdo_en", {31'd0, tdo_en}, 32'd1);
      trst_n = 1'b0;
      #1;
      checkOutput("async_tlr", {31'd0, tlr}, 32'd1);
      checkOutput("async_tdo_en", {31'd0, tdo_en}, 32'd0);
      checkOutput("async_tdo", {31'd0, tdo}, 32'd0);
      checkOutput("async_ir_out", {28'd0, ir_out}, {28'd0, RESET_OP});
      applyStimulus(1'b1, 1'b1);
      trst_n = 1'b1;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("post_trst_tlr", {31'd0, tlr}, 32'd0);
      checkOutput("post_trst_ir_out", {28'd0, ir_out}, {28'd0, RESET_OP});
      checkOutput("post_trst_dr_sel", {30'd0, dr_sel}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jtag_tap_ir_ctrl.md
Name: jtag_tap_ir_ctrl

Overview:
Parametrised JTAG TAP controller with an integrated instruction register, bypass register and DR-select decode. It runs the 16-state IEEE 1149.1 TAP FSM and owns the IR shift/update path. It selects one of NUM_USER_DR external data chains, the bypass register or the optional IDCODE register onto tdo. It sits between the chip's JTAG pins and user DR chains, and replaces the standalone IR register plus external FSM.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
NUM_USER_DR, 2, number of external user data chains (1..8)
USER_OP_BASE, 4'h2, opcode of user chain 0; chain k uses USER_OP_BASE+k
IDCODE_OP, 4'h1, IDCODE opcode (used only with JTAG_IDCODE_EN)
IDCODE_VALUE, 32'h1000_0001, IDCODE contents; bit0 must be 1

Ports:
tck  in  1  JTAG clock; single clock domain; both edges used
trst_n  in  1  asynchronous active-low reset
tms  in  1  mode select, sampled on rising tck
tdi  in  1  serial data in, sampled on rising tck
tdo  out  1  serial data out, launched on falling tck
tdo_en  out  1  tdo output enable
user_tdo  in  NUM_USER_DR  serial out of each user chain
dr_sel  out  NUM_USER_DR  one-hot select of active user chain
capture_dr  out  1  state == Capture-DR
shift_dr  out  1  state == Shift-DR
update_dr  out  1  state == Update-DR
tlr  out  1  state == Test-Logic-Reset
ir_out  out  IR_WIDTH  current (updated) instruction

Behaviour:
- Clock tck; reset trst_n is asynchronous, active-low. Reset forces: state=Test-Logic-Reset (TLR), IR shift reg=0, ir_out=reset opcode, bypass=0, tdo=0, tdo_en=0.
- Reset opcode: IDCODE_OP with JTAG_IDCODE_EN, else all-ones (BYPASS).
- FSM: standard 16 states, one transition per rising tck on tms. Five consecutive tms=1 reach TLR from any state. While in TLR, ir_out is held at the reset opcode.
- Capture-IR: IR shift reg loads {0..0,2'b01}.
- Shift-IR: shift right each rising tck; tdi enters MSB; LSB drives tdo.
- Update-IR: ir_out <= IR shift reg on the rising tck that leaves Update-IR. ir_out is otherwise stable, including during Shift-IR.
- Decode of ir_out:
  - all-ones -> bypass
  - USER_OP_BASE+k, k<NUM_USER_DR -> dr_sel[k]=1
  - IDCODE_OP (when enabled) -> idcode
  - any other value -> bypass
  - dr_sel is 0 for bypass/idcode. dr_sel is combinational from ir_out and valid in all states.
- Bypass register: clears on Capture-DR; loads tdi on Shift-DR. Gives 1-cycle tdi->tdo delay.
- tdo mux: Shift-IR -> IR LSB; Shift-DR -> selected source (bypass, idcode LSB, user_tdo[k]).
- tdo and tdo_en are registered on falling tck. tdo_en=1 only in Shift-IR/Shift-DR, else 0. tdo holds its last value when disabled.
- capture_dr, shift_dr, update_dr and tlr are combinational decodes of the state register, glitch-free (one-hot or Gray-safe state encoding).
- trst_n asserted mid-shift: IR contents are discarded; ir_out returns to the reset opcode immediately (async); tdo_en drops immediately.
- Parameter check: USER_OP_BASE+NUM_USER_DR-1 must be < all-ones and must not equal IDCODE_OP. Violation triggers an elaboration-time $error.

Optional Feature:
JTAG_IDCODE_EN:
- Defined: includes a 32-bit IDCODE register. It loads IDCODE_VALUE on Capture-DR when ir_out==IDCODE_OP. In Shift-DR it shifts right with tdi into MSB. IDCODE is the reset instruction.
- Undefined: no IDCODE register; IDCODE_OP decodes as bypass; reset instruction is all-ones.

Test Plan:
- Hold trst_n=0, release; sample outputs -> tlr=1, tdo_en=0, ir_out=4'h1 (IDCODE_EN) or 4'hF.
- From Shift-DR, apply tms=1 x5 -> tlr=1 on the 5th rising edge; ir_out returns to the reset opcode.
- IR scan shifting in 4'h3 -> first 4 tdo bits are 1,0,0,0 (capture 01, LSB first); after Update-IR, ir_out=4'h3 and dr_sel=2'b10.
- With ir_out=4'hF, Shift-DR tdi pattern 1,0,1,1 -> tdo yields 0,1,0,1 (leading bypass 0, then 1-cycle delay).
- With IDCODE_EN, reset then DR scan 32 bits -> tdo shows 32'h1000_0001 LSB first. Without it, the same scan -> single 0 then the tdi echo.
- Assert trst_n after 2 bits of an IR shift of 4'h2 -> immediate tlr=1, tdo_en=0; ir_out stays at the reset opcode, not 4'h2.
